bsg_fifo_yumi_packer: RTL and testbench
=======================================

Name: bsg_fifo_yumi_packer

Overview:
- Drain-side consumer for the small hardened 1r1w FIFO.
- Pops words from the FIFO's valid/yumi read port and packs els_p consecutive words into one wide beat.
- Presents the wide beat downstream on a valid/ready-and interface.
- A flush input emits a partially filled beat, with a slot mask marking which slots hold data.

Parameters:
- width_p, 16, width of one FIFO word.
- els_p, 4, words per packed beat (>=2).
- lg_els_lp, derived = $clog2(els_p+1), width of the internal fill counter.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- reset_i  input  1  asynchronous active-high reset.
- v_i  input  1  FIFO read-side valid.
- data_i  input  width_p  FIFO head word; valid when v_i=1.
- yumi_o  output  1  pop; asserted only in a cycle where v_i=1, and the word is consumed that cycle.
- flush_i  input  1  request to close the current partial beat.
- v_o  output  1  packed beat valid.
- data_o  output  width_p*els_p  packed beat; slot k at bits [k*width_p +: width_p]; slot 0 holds the oldest word.
- mask_o  output  els_p  bit k=1 iff slot k holds a captured word.
- ready_i  input  1  downstream ready; handshake when v_o & ready_i.

Behaviour:
- Reset (asynchronous, takes effect immediately, also mid-operation):
  - state=COLLECT, cnt=0, data_o=0, mask_o=0, v_o=0, yumi_o=0.
  - Any partial beat is discarded.
- State COLLECT:
  - v_o=0.
  - yumi_o = v_i (combinational from v_i; legal under the yumi protocol).
  - On a pop: write data_i into slot cnt, set mask_o[cnt], cnt<=cnt+1.
  - If that pop fills slot els_p-1, go to EMIT next cycle.
  - Else if flush_i=1 and (cnt>0 or a pop occurs this cycle), go to EMIT next cycle. The word popped in the same cycle is included in the beat.
  - flush_i with cnt=0 and no pop is ignored.
- State EMIT:
  - v_o=1, yumi_o=0.
  - data_o and mask_o are held stable until the handshake.
  - flush_i is ignored.
  - On v_o & ready_i: next cycle data_o=0, mask_o=0, cnt=0, state=COLLECT.
  - No pop occurs in the handshake cycle (one-cycle bubble).
  - Full-beat throughput is els_p words per els_p+1 cycles.
- Latency:
  - v_o rises the cycle after the filling pop or the flush.
  - A word popped at cycle t is visible on data_o no later than cycle t+1.
- Ordering: words land in slots strictly in pop order; no word is dropped or duplicated.
- Mask invariant: mask_o is always contiguous from bit 0 (thermometer); popcount(mask_o) equals cnt.
- Unfilled slots of a flushed beat read 0.
- v_i falling while in COLLECT: no pop; state and cnt hold.
- ready_i asserted during COLLECT: no effect.
- Reset asserted during EMIT: v_o drops asynchronously to 0.

Test Plan:
- Full beat: push 0x1111,0x2222,0x3333,0x4444 into the FIFO, ready_i=1 → single beat, data_o=0x4444_3333_2222_1111, mask_o=4'b1111; yumi_o pulses exactly 4 times.
- Backpressure: fill one beat with ready_i=0 for 10 cycles → v_o held high and data_o stable; yumi_o=0 throughout even with FIFO non-empty; after ready_i=1, the next beat starts collecting one cycle later.
- Partial flush: push 0xAAAA,0xBBBB, then pulse flush_i → data_o=0x0000_0000_BBBB_AAAA, mask_o=4'b0011; flush_i pulsed with cnt=0 → no beat emitted.
- Flush coincident with pop: cnt=2, v_i=1 and flush_i=1 in the same cycle → beat has mask_o=4'b0111 with the third word in slot 2.
- Streaming: push 12 random words back-to-back with ready_i toggling randomly → exactly 3 beats, words in order, no loss or duplication; scoreboard compares against the input sequence.
- Async reset mid-collect: after 2 pops, assert reset_i between clock edges → v_o, mask_o and data_o go to 0 immediately; after deassert, the next 4 pushes form a fresh full beat with no stale data.

Source files
------------

// File: rtl/bsg_fifo_yumi_packer.sv
// Drains a valid/yumi FIFO read port and packs els_p words into one wide beat,
// presented downstream on valid/ready; flush_i closes a partially filled beat.
//
// state   | meaning
// COLLECT | popping words into slots 0..els_p-1, v_o low
// EMIT    | beat held on data_o/mask_o with v_o high until ready_i
module bsg_fifo_yumi_packer #(
  parameter int width_p = 16,
  parameter int els_p   = 4
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       v_i,
  input  logic [width_p-1:0]         data_i,
  output logic                       yumi_o,
  input  logic                       flush_i,
  output logic                       v_o,
  output logic [width_p*els_p-1:0]   data_o,
  output logic [els_p-1:0]           mask_o,
  input  logic                       ready_i
);

  localparam int lg_els_lp = $clog2(els_p + 1);

  typedef enum logic {COLLECT, EMIT} state_e;

  state_e                     state_r, state_n;
  logic [lg_els_lp-1:0]       cnt_r, cnt_n;
  logic [width_p*els_p-1:0]   data_r, data_n;
  logic [els_p-1:0]           mask_r, mask_n;
  logic                       pop;
  logic                       last_slot;

  // Pop is gated by reset so yumi_o is never asserted while the block is held in reset.
  assign pop       = (state_r == COLLECT) & v_i & ~reset_i;
  assign last_slot = (cnt_r == lg_els_lp'(els_p - 1));

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r <= COLLECT;
      cnt_r   <= '0;
      data_r  <= '0;
      mask_r  <= '0;
    end else begin
      state_r <= state_n;
      cnt_r   <= cnt_n;
      data_r  <= data_n;
      mask_r  <= mask_n;
    end
  end

  always_comb begin
    state_n = state_r;
    cnt_n   = cnt_r;
    data_n  = data_r;
    mask_n  = mask_r;
    case (state_r)
      COLLECT: begin
        if (pop) begin
          for (int k = 0; k < els_p; k++) begin
            if (cnt_r == lg_els_lp'(k)) begin
              data_n[k*width_p +: width_p] = data_i;
              mask_n[k]                    = 1'b1;
            end
          end
          cnt_n = cnt_r + lg_els_lp'(1);
        end
        // A flush with nothing captured and nothing arriving has no beat to close.
        if ((pop && last_slot) || (flush_i && ((cnt_r != '0) || pop))) begin
          state_n = EMIT;
        end
      end
      EMIT: begin
        if (ready_i) begin
          state_n = COLLECT;
          cnt_n   = '0;
          data_n  = '0;
          mask_n  = '0;
        end
      end
      default: state_n = COLLECT;
    endcase
  end

  assign yumi_o = pop;
  assign v_o    = (state_r == EMIT);
  assign data_o = data_r;
  assign mask_o = mask_r;

endmodule

// File: tb/tb_bsg_fifo_yumi_packer.sv
// Self-checking bench for bsg_fifo_yumi_packer: a FIFO model feeds the read port
// and expected beats are queued at stimulus time, then compared on each handshake.
module tb_bsg_fifo_yumi_packer;

  localparam int W = 16;
  localparam int E = 4;

  logic           clk_i = 1'b0;
  logic           reset_i;
  logic           v_i;
  logic [W-1:0]   data_i;
  logic           yumi_o;
  logic           flush_i;
  logic           v_o;
  logic [W*E-1:0] data_o;
  logic [E-1:0]   mask_o;
  logic           ready_i;

  typedef struct packed {
    logic [W*E-1:0] d;
    logic [E-1:0]   m;
  } beat_t;

  logic [W-1:0] fifo_q[$];
  beat_t        exp_q[$];
  int           checks = 0;
  int           errors = 0;

  bsg_fifo_yumi_packer #(.width_p(W), .els_p(E)) dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .v_i     (v_i),
    .data_i  (data_i),
    .yumi_o  (yumi_o),
    .flush_i (flush_i),
    .v_o     (v_o),
    .data_o  (data_o),
    .mask_o  (mask_o),
    .ready_i (ready_i)
  );

  always #5 clk_i = ~clk_i;

  // Called just after a rising edge: drives one cycle, samples mid-cycle, advances.
  task automatic tick(input logic fl, input logic rd, output logic y, output logic v,
                      output logic [W*E-1:0] d, output logic [E-1:0] m);
    v_i     = (fifo_q.size() > 0);
    data_i  = v_i ? fifo_q[0] : '0;
    flush_i = fl;
    ready_i = rd;
    #3;
    y = yumi_o;
    v = v_o;
    d = data_o;
    m = mask_o;
    if (y && fifo_q.size() > 0) void'(fifo_q.pop_front());
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    v_i     = 1'b1;
    data_i  = 16'h7777;
    flush_i = 1'b1;
    ready_i = 1'b1;
    #3;
    checks++;
    if (v_o !== 1'b0) begin errors++; $display("FAIL reset_v_o: got %b want 0", v_o); end
    checks++;
    if (yumi_o !== 1'b0) begin errors++; $display("FAIL reset_yumi: got %b want 0", yumi_o); end
    checks++;
    if (mask_o !== '0) begin errors++; $display("FAIL reset_mask: got %b want 0", mask_o); end
    checks++;
    if (data_o !== '0) begin errors++; $display("FAIL reset_data: got %h want 0", data_o); end
    @(negedge clk_i);
    v_i     = 1'b0;
    flush_i = 1'b0;
    reset_i = 1'b0;
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_full_beat();
    logic y, v;
    logic [W*E-1:0] d;
    logic [E-1:0] m;
    beat_t e;
    int pops = 0, beats = 0, vcyc = -1;
    fifo_q.push_back(16'h1111);
    fifo_q.push_back(16'h2222);
    fifo_q.push_back(16'h3333);
    fifo_q.push_back(16'h4444);
    exp_q.push_back('{d: 64'h4444_3333_2222_1111, m: 4'b1111});
    for (int c = 0; c < 10; c++) begin
      tick(1'b0, 1'b1, y, v, d, m);
      if (y) pops++;
      if (v) begin
        if (vcyc < 0) vcyc = c;
        beats++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL full_beat_extra: unexpected beat %h", d);
        end else begin
          e = exp_q.pop_front();
          if (d !== e.d || m !== e.m) begin
            errors++; $display("FAIL full_beat_data: got %h/%b want %h/%b", d, m, e.d, e.m);
          end
        end
      end
    end
    checks++;
    if (pops != 4) begin errors++; $display("FAIL full_beat_pops: got %0d want 4", pops); end
    checks++;
    if (beats != 1) begin errors++; $display("FAIL full_beat_count: got %0d want 1", beats); end
    checks++;
    if (vcyc != 4) begin errors++; $display("FAIL full_beat_latency: v_o at cycle %0d want 4", vcyc); end
  endtask

  task automatic test_backpressure();
    logic y, v, rd;
    logic [W*E-1:0] d;
    logic [E-1:0] m;
    beat_t e;
    int beats = 0, hs1 = -1;
    for (int i = 0; i < 8; i++) fifo_q.push_back(16'(16'h1000 + i));
    exp_q.push_back('{d: 64'h1003_1002_1001_1000, m: 4'b1111});
    exp_q.push_back('{d: 64'h1007_1006_1005_1004, m: 4'b1111});
    for (int c = 0; c < 30; c++) begin
      rd = (c >= 14);
      tick(1'b0, rd, y, v, d, m);
      if (c >= 4 && c < 14) begin
        checks++;
        if (v !== 1'b1 || y !== 1'b0 || d !== 64'h1003_1002_1001_1000) begin
          errors++; $display("FAIL backpressure_hold c=%0d: v=%b yumi=%b data=%h want 1/0/%h",
                              c, v, y, d, 64'h1003_1002_1001_1000);
        end
      end
      if (hs1 >= 0 && c == hs1 + 1) begin
        checks++;
        if (y !== 1'b1) begin errors++; $display("FAIL backpressure_restart: yumi=%b want 1", y); end
      end
      if (v && rd) begin
        checks++;
        if (y !== 1'b0) begin errors++; $display("FAIL backpressure_bubble: yumi=%b want 0", y); end
        if (hs1 < 0) hs1 = c;
        beats++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL backpressure_extra: unexpected beat %h", d);
        end else begin
          e = exp_q.pop_front();
          if (d !== e.d || m !== e.m) begin
            errors++; $display("FAIL backpressure_data: got %h/%b want %h/%b", d, m, e.d, e.m);
          end
        end
      end
    end
    checks++;
    if (beats != 2) begin errors++; $display("FAIL backpressure_count: got %0d want 2", beats); end
  endtask

  task automatic test_partial_flush();
    logic y, v;
    logic [W*E-1:0] d;
    logic [E-1:0] m;
    beat_t e;
    int beats = 0, vcyc = -1;
    fifo_q.push_back(16'hAAAA);
    fifo_q.push_back(16'hBBBB);
    exp_q.push_back('{d: 64'h0000_0000_BBBB_AAAA, m: 4'b0011});
    for (int c = 0; c < 10; c++) begin
      tick(c == 2, 1'b1, y, v, d, m);
      if (v) begin
        if (vcyc < 0) vcyc = c;
        beats++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL partial_flush_extra: unexpected beat %h", d);
        end else begin
          e = exp_q.pop_front();
          if (d !== e.d || m !== e.m) begin
            errors++; $display("FAIL partial_flush_data: got %h/%b want %h/%b", d, m, e.d, e.m);
          end
        end
      end
    end
    checks++;
    if (beats != 1 || vcyc != 3) begin
      errors++; $display("FAIL partial_flush_count: beats=%0d at cycle %0d want 1 at 3", beats, vcyc);
    end
    for (int c = 0; c < 6; c++) begin
      tick(c == 0, 1'b1, y, v, d, m);
      checks++;
      if (v !== 1'b0 || m !== '0) begin
        errors++; $display("FAIL empty_flush c=%0d: v=%b mask=%b want 0/0", c, v, m);
      end
    end
  endtask

  task automatic test_flush_with_pop();
    logic y, v;
    logic [W*E-1:0] d;
    logic [E-1:0] m;
    beat_t e;
    int beats = 0, vcyc = -1;
    fifo_q.push_back(16'h5A01);
    fifo_q.push_back(16'h5A02);
    fifo_q.push_back(16'h5A03);
    exp_q.push_back('{d: 64'h0000_5A03_5A02_5A01, m: 4'b0111});
    for (int c = 0; c < 10; c++) begin
      tick(c == 2, 1'b1, y, v, d, m);
      if (v) begin
        if (vcyc < 0) vcyc = c;
        beats++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL flush_pop_extra: unexpected beat %h", d);
        end else begin
          e = exp_q.pop_front();
          if (d !== e.d || m !== e.m) begin
            errors++; $display("FAIL flush_pop_data: got %h/%b want %h/%b", d, m, e.d, e.m);
          end
        end
      end
    end
    checks++;
    if (beats != 1 || vcyc != 3 || fifo_q.size() != 0) begin
      errors++; $display("FAIL flush_pop_count: beats=%0d cycle=%0d left=%0d want 1/3/0",
                          beats, vcyc, fifo_q.size());
    end
  endtask

  task automatic test_streaming();
    logic y, v, rd;
    logic [W*E-1:0] d;
    logic [E-1:0] m;
    logic [W-1:0] w;
    beat_t e;
    int beats = 0;
    for (int b = 0; b < 3; b++) begin
      e.d = '0;
      e.m = 4'b1111;
      for (int j = 0; j < E; j++) begin
        w = 16'($urandom);
        fifo_q.push_back(w);
        e.d[j*W +: W] = w;
      end
      exp_q.push_back(e);
    end
    for (int c = 0; c < 200 && beats < 3; c++) begin
      rd = 1'($urandom_range(0, 1));
      tick(1'b0, rd, y, v, d, m);
      checks++;
      if ((m & (m + 4'd1)) != 4'd0 || (y && !v_i)) begin
        errors++; $display("FAIL stream_invariant c=%0d: mask=%b yumi=%b v_i=%b", c, m, y, v_i);
      end
      if (v && rd) begin
        beats++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL stream_extra: unexpected beat %h", d);
        end else begin
          e = exp_q.pop_front();
          if (d !== e.d || m !== e.m) begin
            errors++; $display("FAIL stream_data: got %h/%b want %h/%b", d, m, e.d, e.m);
          end
        end
      end
    end
    checks++;
    if (beats != 3 || exp_q.size() != 0 || fifo_q.size() != 0) begin
      errors++; $display("FAIL stream_count: beats=%0d pending=%0d left=%0d want 3/0/0",
                          beats, exp_q.size(), fifo_q.size());
    end
  endtask

  task automatic test_async_reset();
    logic y, v;
    logic [W*E-1:0] d;
    logic [E-1:0] m;
    beat_t e;
    int beats = 0;
    fifo_q.push_back(16'hDEAD);
    fifo_q.push_back(16'hBEEF);
    tick(1'b0, 1'b0, y, v, d, m);
    tick(1'b0, 1'b0, y, v, d, m);
    v_i = 1'b0;
    #1;
    checks++;
    if (mask_o !== 4'b0011 || data_o !== 64'h0000_0000_BEEF_DEAD) begin
      errors++; $display("FAIL areset_pre: got %h/%b want %h/0011", data_o, mask_o, 64'h0000_0000_BEEF_DEAD);
    end
    #1;
    reset_i = 1'b1;
    #1;
    checks++;
    if (v_o !== 1'b0 || mask_o !== '0 || data_o !== '0) begin
      errors++; $display("FAIL areset_immediate: v=%b mask=%b data=%h want all 0", v_o, mask_o, data_o);
    end
    @(posedge clk_i);
    #3;
    reset_i = 1'b0;
    @(posedge clk_i);
    #1;
    fifo_q.push_back(16'hC001);
    fifo_q.push_back(16'hC002);
    fifo_q.push_back(16'hC003);
    fifo_q.push_back(16'hC004);
    exp_q.push_back('{d: 64'hC004_C003_C002_C001, m: 4'b1111});
    for (int c = 0; c < 10; c++) begin
      tick(1'b0, 1'b1, y, v, d, m);
      if (v) begin
        beats++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL areset_extra: unexpected beat %h/%b", d, m);
        end else begin
          e = exp_q.pop_front();
          if (d !== e.d || m !== e.m) begin
            errors++; $display("FAIL areset_data: got %h/%b want %h/%b", d, m, e.d, e.m);
          end
        end
      end
    end
    checks++;
    if (beats != 1) begin errors++; $display("FAIL areset_count: got %0d want 1", beats); end
  endtask

  initial begin
    test_reset();
    test_full_beat();
    test_backpressure();
    test_partial_flush();
    test_flush_with_pop();
    test_streaming();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
